uart_rx_deser_param: RTL and testbench
======================================

// Module: uart_rx_deser_param
// PURPOSE
// - Parametrised UART RX deserializer. Sits between the RX bit sampler and the frame checker/FSM.
// - Captures one sampled bit per bit period when the oversampling edge counter hits Prescale-1.
// - Supports runtime data length and LSB/MSB-first order, and computes running parity.
// - Publishes a registered word plus a one-cycle done pulse once the configured number of bits is in.
// PARAMETERS
// - DATA_W   default 8 : max data bits per frame (legal 5..16)
// - PRESC_W  default 6 : width of Prescale and edge_cnt (supports oversampling up to 2**PRESC_W-1)
// - LEN_W    default 5 : width of data_len; must satisfy 2**LEN_W > DATA_W
// PORTS
// - CLK          in   1        system clock; all logic is rising-edge
// - RST          in   1        asynchronous, active-high reset
// - sampled_bit  in   1        majority-voted bit from the sampler
// - deser_en     in   1        high for the whole data field, from the RX FSM
// - edge_cnt     in   PRESC_W  oversampling edge counter within the current bit
// - Prescale     in   PRESC_W  oversampling ratio (8/16/32 typical)
// - data_len     in   LEN_W    number of data bits per frame, 5..DATA_W
// - msb_first    in   1        0 = LSB first (UART standard), 1 = MSB first
// - P_DATA       out  DATA_W   last completed word, right-aligned, upper unused bits 0
// - deser_done   out  1        one-cycle pulse when P_DATA updates
// - par_calc     out  1        XOR of all bits of the last completed word
// - bit_idx      out  LEN_W    bits captured so far in the current frame
// BEHAVIOUR
// - Reset (async, RST=1): P_DATA=0, deser_done=0, par_calc=0, bit_idx=0, internal shift=0, parity acc=0, full=0.
// - Capture strobe cap = deser_en & ~full & (Prescale>=2) & (edge_cnt == Prescale-1).
//   - Compare is done in PRESC_W bits.
//   - Prescale 0 or 1 never captures.
// - On cap at arrival index k = bit_idx:
//   - LSB-first: shift[k] <= sampled_bit.
//   - MSB-first: shift[data_len-1-k] <= sampled_bit.
//   - acc <= acc ^ sampled_bit; bit_idx <= k+1.
// - Completion: the cap with k == data_len-1 causes the following on the next edge:
//   - P_DATA <= completed word, including the bit from this cap;
//   - par_calc <= final acc, including this bit;
//   - deser_done=1 for exactly one cycle; full <= 1.
//   - Latency is 1 clock from the last capture edge to deser_done/P_DATA.
// - While full=1, further strobes are ignored. bit_idx holds at data_len. P_DATA and par_calc are stable.
// - deser_en=0 (any cycle), at the next edge:
//   - bit_idx=0, shift=0, acc=0, full=0;
//   - P_DATA, par_calc and deser_done are not affected (abort mid-frame leaves the previous word intact).
// - deser_en falling in the same cycle as the completing cap: completion wins, and the clear applies on the following cycle.
// - data_len and msb_first are sampled per capture. Changing them mid-frame is illegal; the result is undefined but must not lock up (deser_en low always recovers).
// - data_len outside 5..DATA_W is clamped to DATA_W.
// - Bits above data_len-1 in P_DATA are always 0.
// - RST asserted mid-frame: immediate clear to reset values; no deser_done is generated.
// TESTING
// - Prescale=8, len=8, LSB, stream 1,0,1,1,0,0,1,0 -> P_DATA=8'h4D, par_calc=0, one deser_done pulse 1 clk after 8th strobe.
// - Same stream, msb_first=1 -> P_DATA=8'hB2, par_calc=0.
// - Prescale=16, len=5, LSB, bits 1,1,1,0,1 -> P_DATA=0x17, par_calc=0, bit_idx=5, upper bits 0.
// - deser_en held after done, 3 extra strobes -> P_DATA unchanged, no second deser_done, bit_idx stays 5.
// - deser_en dropped after 4 of 8 bits, then a full 0xA5 frame -> no done on abort, P_DATA keeps the prior value, then 0xA5 with par_calc=0.
// - RST pulsed mid-frame (async, between edges) -> outputs 0 immediately. Prescale=1 with deser_en=1 -> no captures, bit_idx=0.

Source files
------------

// File: rtl/uart_rx_deser_param.sv
// UART RX deserializer: captures one sampled bit per bit period, assembles a
// runtime-length word in LSB- or MSB-first order and tracks running parity.
module uart_rx_deser_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PRESC_W = 6,
  parameter int unsigned LEN_W   = 5
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               sampled_bit,
  input  logic               deser_en,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic [LEN_W-1:0]   data_len,
  input  logic               msb_first,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               deser_done,
  output logic               par_calc,
  output logic [LEN_W-1:0]   bit_idx
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DATA_W);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(5);

  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_p_data;
  logic [LEN_W-1:0]  r_bit_idx;
  logic              r_acc;
  logic              r_full;
  logic              r_done;
  logic              r_par;

  logic [LEN_W-1:0]  w_len_eff;
  logic [LEN_W-1:0]  w_wr_idx;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] w_mask;
  logic              w_cap;
  logic              w_last;

  // Out-of-range lengths fall back to the full data width
  assign w_len_eff = (data_len < LEN_MIN || data_len > LEN_MAX) ? LEN_MAX : data_len;

  assign w_cap = deser_en & ~r_full & (Prescale >= PRESC_W'(2))
               & (edge_cnt == Prescale - PRESC_W'(1));

  // ">=" rather than "==" so an illegal mid-frame length change still terminates
  assign w_last   = (r_bit_idx >= w_len_eff - LEN_W'(1));
  assign w_wr_idx = msb_first ? (w_len_eff - LEN_W'(1) - r_bit_idx) : r_bit_idx;
  assign w_mask   = ~({DATA_W{1'b1}} << w_len_eff);

  // Out-of-range write indices (only reachable illegally) are dropped
  always_comb begin
    w_shift_nxt = r_shift;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (LEN_W'(i) == w_wr_idx) w_shift_nxt[i] = sampled_bit;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shift   <= '0;
      r_p_data  <= '0;
      r_bit_idx <= '0;
      r_acc     <= 1'b0;
      r_full    <= 1'b0;
      r_done    <= 1'b0;
      r_par     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_cap) begin
        r_shift   <= w_shift_nxt;
        r_acc     <= r_acc ^ sampled_bit;
        r_bit_idx <= r_bit_idx + LEN_W'(1);
        if (w_last) begin
          r_p_data <= w_shift_nxt & w_mask;
          r_par    <= r_acc ^ sampled_bit;
          r_done   <= 1'b1;
          r_full   <= 1'b1;
        end
      end else if (!deser_en) begin
        // Frame clear; the published word survives an abort
        r_shift   <= '0;
        r_bit_idx <= '0;
        r_acc     <= 1'b0;
        r_full    <= 1'b0;
      end
    end
  end

  assign P_DATA     = r_p_data;
  assign deser_done = r_done;
  assign par_calc   = r_par;
  assign bit_idx    = r_bit_idx;

endmodule

// File: tb/tb_uart_rx_deser_param.sv
// Directed bench for uart_rx_deser_param: frames, order, length, parity,
// hold-after-done, abort, clamp, async reset and degenerate prescale.
module tb_uart_rx_deser_param;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       sampled_bit = 1'b0;
  logic       deser_en = 1'b0;
  logic [5:0] edge_cnt = '0;
  logic [5:0] Prescale = 6'd8;
  logic [4:0] data_len = 5'd8;
  logic       msb_first = 1'b0;
  logic [7:0] P_DATA;
  logic       deser_done;
  logic       par_calc;
  logic [4:0] bit_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int d0;

  uart_rx_deser_param dut (
    .CLK(CLK), .RST(RST), .sampled_bit(sampled_bit), .deser_en(deser_en),
    .edge_cnt(edge_cnt), .Prescale(Prescale), .data_len(data_len),
    .msb_first(msb_first), .P_DATA(P_DATA), .deser_done(deser_done),
    .par_calc(par_calc), .bit_idx(bit_idx)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (deser_done) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One bit period: edge_cnt sweeps 0..presc-1, capture on the last step
  task automatic send_bit(input logic b, input int presc);
    for (int e = 0; e < presc; e++) begin
      sampled_bit = b;
      edge_cnt    = 6'(e);
      tick();
    end
    edge_cnt = '0;
  endtask

  // arr[i] is the i-th bit to arrive on the line
  task automatic send_bits(input logic [15:0] arr, input int n, input int presc);
    deser_en = 1'b1;
    for (int i = 0; i < n; i++) send_bit(arr[i], presc);
  endtask

  task automatic idle();
    deser_en = 1'b0;
    tick();
  endtask

  task automatic frame(input string tag, input logic [15:0] arr, input int n, input int presc,
                       input logic [7:0] exp_data, input logic exp_par, input logic [4:0] exp_idx);
    idle();
    d0 = done_cnt;
    send_bits(arr, n, presc);
    check_eq({tag, "_done_lat"}, 32'(deser_done), 32'd1);
    check_eq({tag, "_data"}, 32'(P_DATA), 32'(exp_data));
    check_eq({tag, "_par"}, 32'(par_calc), 32'(exp_par));
    check_eq({tag, "_idx"}, 32'(bit_idx), 32'(exp_idx));
    tick();
    check_eq({tag, "_done_1cyc"}, 32'(deser_done), 32'd0);
    check_eq({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #12;
    check_eq("rst_data", 32'(P_DATA), 32'd0);
    check_eq("rst_idx", 32'(bit_idx), 32'd0);
    check_eq("rst_done", 32'(deser_done), 32'd0);
    check_eq("rst_par", 32'(par_calc), 32'd0);
    RST = 1'b0;
    tick();

    Prescale = 6'd8; data_len = 5'd8; msb_first = 1'b0;
    frame("lsb8", 16'h004D, 8, 8, 8'h4D, 1'b0, 5'd8);

    msb_first = 1'b1;
    frame("msb8", 16'h004D, 8, 8, 8'hB2, 1'b0, 5'd8);

    Prescale = 6'd16; data_len = 5'd5; msb_first = 1'b0;
    frame("len5", 16'h0017, 5, 16, 8'h17, 1'b0, 5'd5);

    // Strobes after completion are ignored while enable stays high
    d0 = done_cnt;
    send_bits(16'h0007, 3, 16);
    tick();
    check_eq("hold_data", 32'(P_DATA), 32'h17);
    check_eq("hold_idx", 32'(bit_idx), 32'd5);
    check_eq("hold_nodone", 32'(done_cnt - d0), 32'd0);

    // Abort after 4 of 8 bits keeps the previous word
    Prescale = 6'd8; data_len = 5'd8;
    idle();
    d0 = done_cnt;
    send_bits(16'h00FF, 4, 8);
    check_eq("abort_idx_mid", 32'(bit_idx), 32'd4);
    idle();
    tick();
    check_eq("abort_idx", 32'(bit_idx), 32'd0);
    check_eq("abort_data", 32'(P_DATA), 32'h17);
    check_eq("abort_nodone", 32'(done_cnt - d0), 32'd0);
    frame("a5", 16'h00A5, 8, 8, 8'hA5, 1'b0, 5'd8);

    // Out-of-range length clamps to 8; odd parity word
    data_len = 5'd3;
    frame("clamp", 16'h0037, 8, 8, 8'h37, 1'b1, 5'd8);

    data_len = 5'd6; msb_first = 1'b1;
    frame("msb6", 16'h0039, 6, 8, 8'h27, 1'b0, 5'd6);

    // Async reset between edges clears immediately
    msb_first = 1'b0; data_len = 5'd8;
    idle();
    send_bits(16'h0005, 3, 8);
    #2 RST = 1'b1;
    #1;
    check_eq("arst_data", 32'(P_DATA), 32'd0);
    check_eq("arst_idx", 32'(bit_idx), 32'd0);
    check_eq("arst_par", 32'(par_calc), 32'd0);
    #2 RST = 1'b0;
    deser_en = 1'b0;
    tick();
    tick();

    // Prescale of 1 and 0 never capture
    d0 = done_cnt;
    Prescale = 6'd1;
    deser_en = 1'b1;
    sampled_bit = 1'b1;
    edge_cnt = '0;
    for (int i = 0; i < 10; i++) tick();
    check_eq("presc1_idx", 32'(bit_idx), 32'd0);
    Prescale = 6'd0;
    edge_cnt = 6'h3F;
    for (int i = 0; i < 10; i++) tick();
    check_eq("presc0_idx", 32'(bit_idx), 32'd0);
    check_eq("presc_nodone", 32'(done_cnt - d0), 32'd0);
    check_eq("presc_data", 32'(P_DATA), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
